apb_rr_master: RTL and testbench
================================

Name: apb_rr_master

Overview:
- Round-robin APB master that shares one APB slave between NUM_REQ requesters.
- Accepts simple request/grant/done transactions from each requester and drives the APB SETUP→ACCESS sequence on the slave bus.
- Returns read data and a completion pulse to the originating requester.
- Sits between the system-side requesters and the existing 8-bit-address APB slave.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 8, APB address width.
- DATA_W, 8, APB write/read data width.

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester request; held high with fields stable until gnt.
- req_write  input  NUM_REQ  per-requester direction; 1 = write, 0 = read.
- req_addr  input  NUM_REQ*ADDR_W  per-requester address, packed; requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_wdata  input  NUM_REQ*DATA_W  per-requester write data, packed the same way.
- gnt  output  NUM_REQ  one-cycle pulse: request accepted and fields latched.
- done  output  NUM_REQ  one-cycle pulse: transaction complete.
- rdata  output  DATA_W  read data; valid while done is high for a read.
- busy  output  1  high whenever state != IDLE.
- psel  output  1  APB select.
- penable  output  1  APB enable.
- pwrite  output  1  APB direction.
- paddr  output  ADDR_W  APB address.
- pwdata  output  DATA_W  APB write data.
- prdata  input  DATA_W  APB read data from the slave.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - state=IDLE, rr pointer=0.
  - gnt, done, rdata, psel, penable, pwrite, paddr, pwdata all 0; busy=0.
  - A reset mid-transaction aborts it: no done is issued, and the latched request is discarded.
- All outputs are registered.
- States: IDLE, SETUP, ACCESS, CAPTURE.
- IDLE:
  - psel=0, penable=0.
  - If any req bit is set, select winner w by round-robin, searching from pointer upward and wrapping at NUM_REQ-1 → 0.
  - At the edge: latch req_write[w], req_addr[w], req_wdata[w] onto pwrite/paddr/pwdata; gnt[w]=1 for the next cycle; pointer=(w+1) mod NUM_REQ; go to SETUP.
  - With no request, stay in IDLE; pointer unchanged.
- SETUP: psel=1, penable=0; always go to ACCESS.
- ACCESS:
  - psel=1, penable=1.
  - Write: next state IDLE, done[w]=1 next cycle.
  - Read: next state CAPTURE.
- CAPTURE:
  - psel=0, penable=0.
  - At the edge: rdata<=prdata, done[w]=1 next cycle; go to IDLE.
- paddr, pwrite and pwdata hold their values from the latch until the next grant; they do not return to 0 after a transaction.
- Latency from req sampled in IDLE at cycle T:
  - gnt at T+1 (SETUP), ACCESS at T+2.
  - Write done at T+3.
  - Read done at T+4, rdata valid that cycle.
- Back-to-back transfers always pass through one IDLE cycle. The done cycle coincides with that IDLE cycle, so arbitration in the same cycle is allowed.
- rdata holds its value until the next read capture.
- A requester may drop req after gnt; this has no effect, because fields are already latched.
- A req still high after its own gnt is treated as a new request.
- Simultaneous requests: exactly one gnt bit is set per grant; the others wait with no starvation.
  - Bound: each requester waits at most NUM_REQ-1 transactions.
- done and gnt are never set for more than one requester in the same cycle.

Decomposition:
- Package apb_pkg:
  - state enum (IDLE, SETUP, ACCESS, CAPTURE) as 2-bit typedef;
  - default ADDR_W/DATA_W constants.
- Sub-module rr_arbiter:
  - inputs: req, pointer, enable;
  - outputs: one-hot grant and winner index;
  - purely combinational; the pointer register stays in apb_rr_master.

Test Plan:
- Single write: req[0]=1, addr=0x10, wdata=0xA5, write=1 → gnt[0] at T+1; psel=1/penable=0 at T+1; psel=1/penable=1 at T+2 with paddr=0x10, pwdata=0xA5; done[0] at T+3.
- Read-after-write: requester 1 reads 0x10 after the write of 0xA5 → slave prdata=0xA5 sampled in CAPTURE; done[1] with rdata=0xA5 at T+4.
- Contention: req=2'b11 held continuously, pointer=0 → grants alternate 0,1,0,1; each gnt is one cycle; no back-to-back repeat of the same requester.
- Wrap-around with NUM_REQ=4: pointer=3, req=4'b1001 → grant to 3, then 0.
- Reset mid-transfer: assert rst during ACCESS → next cycle all outputs 0, state IDLE, no done; a subsequent req[0] completes normally.
- Idle bus: req=0 for 20 cycles → psel=0, busy=0, no gnt or done pulses, pointer unchanged.

Source files
------------

// File: rtl/apb_rr_master_pkg.sv
// Shared constants for the round-robin APB master: default bus widths and
// the 2-bit FSM state encoding (kept as plain constants so older tools and
// waveform viewers see stable numeric values).
package apb_pkg;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_SETUP   = 2'd1;
  localparam state_t ST_ACCESS  = 2'd2;
  localparam state_t ST_CAPTURE = 2'd3;

endpackage

// File: rtl/apb_rr_master_if.sv
// Bundle of requester-side handshake signals and APB slave-side signals.
// The master modport is the arbiter/APB master view; the slave modport is
// the view of whatever drives the requests and models the APB slave.
interface apb_rr_master_if
  import apb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W
);

  // Requester side
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        done;
  logic [DATA_W-1:0]         rdata;
  logic                      busy;

  // APB side
  logic                      psel;
  logic                      penable;
  logic                      pwrite;
  logic [ADDR_W-1:0]         paddr;
  logic [DATA_W-1:0]         pwdata;
  logic [DATA_W-1:0]         prdata;

  modport master (
    input  req, req_write, req_addr, req_wdata, prdata,
    output gnt, done, rdata, busy, psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output req, req_write, req_addr, req_wdata, prdata,
    input  gnt, done, rdata, busy, psel, penable, pwrite, paddr, pwdata
  );

endinterface

// File: rtl/apb_rr_master_rr_arbiter.sv
// Combinational round-robin picker: scans the request vector starting at
// the supplied pointer, wrapping from NUM_REQ-1 back to 0, and reports the
// first asserted request as a one-hot grant plus its index. The pointer
// register itself lives in the caller.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  input  logic               i_enable,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [PTR_W-1:0]   o_winner,
  output logic               o_valid
);

  logic [PTR_W:0]   w_sum;
  logic [PTR_W-1:0] w_cand;

  // Walk candidates pointer, pointer+1, ... (mod NUM_REQ); first hit wins.
  always_comb begin
    // NOTE: every signal driven here gets a default before the scan, so no path leaves a value held over and no latch is inferred.
    o_grant  = '0;
    o_winner = '0;
    o_valid  = 1'b0;
    w_sum    = '0;
    w_cand   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sum = {1'b0, i_ptr} + (PTR_W+1)'(i);
      if (w_sum >= (PTR_W+1)'(NUM_REQ)) begin
        w_sum = w_sum - (PTR_W+1)'(NUM_REQ);
      end
      w_cand = w_sum[PTR_W-1:0];
      if (i_enable && !o_valid && i_req[w_cand]) begin
        o_valid         = 1'b1;
        o_winner        = w_cand;
        o_grant[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_rr_master.sv
// Round-robin APB master: shares one APB slave between NUM_REQ requesters.
// A request sampled in IDLE is granted, its fields latched onto the APB
// bus, and the transfer runs SETUP -> ACCESS (-> CAPTURE for reads) before
// a one-cycle done pulse returns to the originating requester.
module apb_rr_master
  import apb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W
) (
  input logic             clk,
  input logic             rst,
  apb_rr_master_if.master bus
);

  localparam int PTR_W = $clog2(NUM_REQ);

  state_t              r_state;
  logic [PTR_W-1:0]    r_ptr;
  logic [NUM_REQ-1:0]  r_owner;
  logic [NUM_REQ-1:0]  r_gnt;
  logic [NUM_REQ-1:0]  r_done;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_busy;
  logic                r_psel;
  logic                r_penable;
  logic                r_pwrite;
  logic [ADDR_W-1:0]   r_paddr;
  logic [DATA_W-1:0]   r_pwdata;

  logic [NUM_REQ-1:0]  w_grant;
  logic [PTR_W-1:0]    w_winner;
  logic                w_valid;
  logic                w_arb_en;
  logic [PTR_W-1:0]    w_ptr_next;

  // Arbitration is only meaningful while the bus is free.
  assign w_arb_en   = (r_state == ST_IDLE);
  assign w_ptr_next = (w_winner == PTR_W'(NUM_REQ - 1)) ? '0 : w_winner + PTR_W'(1);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .i_req    (bus.req),
    .i_ptr    (r_ptr),
    .i_enable (w_arb_en),
    .o_grant  (w_grant),
    .o_winner (w_winner),
    .o_valid  (w_valid)
  );

  // Transfer sequencer: grant/latch in IDLE, drive APB phases, pulse done.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values, independent of statement order.
    if (rst) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_owner   <= '0;
      r_gnt     <= '0;
      r_done    <= '0;
      r_rdata   <= '0;
      r_busy    <= 1'b0;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
    end else begin
      // gnt and done are single-cycle pulses unless re-asserted below.
      r_gnt  <= '0;
      r_done <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            r_pwrite <= bus.req_write[w_winner];
            r_paddr  <= bus.req_addr[w_winner*ADDR_W +: ADDR_W];
            r_pwdata <= bus.req_wdata[w_winner*DATA_W +: DATA_W];
            r_owner  <= w_grant;
            r_gnt    <= w_grant;
            r_ptr    <= w_ptr_next;
            r_psel   <= 1'b1;
            r_busy   <= 1'b1;
            r_state  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
          if (r_pwrite) begin
            r_done  <= r_owner;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          r_rdata <= bus.prdata;
          r_done  <= r_owner;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.done    = r_done;
  assign bus.rdata   = r_rdata;
  assign bus.busy    = r_busy;
  assign bus.psel    = r_psel;
  assign bus.penable = r_penable;
  assign bus.pwrite  = r_pwrite;
  assign bus.paddr   = r_paddr;
  assign bus.pwdata  = r_pwdata;

endmodule

// File: tb/tb_apb_rr_master.sv
// Self-checking bench for apb_rr_master with four requesters. Requesters
// are modelled as per-requester operation queues; a transaction-level
// reference (round-robin pick from a pointer, a byte-array slave memory
// and fixed phase latencies) predicts every grant, APB phase and done.
module tb_apb_rr_master;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int QD = 64;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } op_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int errors = 0;
  int checks = 0;

  apb_rr_master_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  apb_rr_master #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  // APB slave: byte memory, preset to a known pattern on reset.
  logic [DW-1:0] slave_mem [256];
  assign bus.prdata = slave_mem[bus.paddr];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) slave_mem[i] <= 8'(i) ^ 8'h5A;
    end else if (bus.psel && bus.penable && bus.pwrite) begin
      slave_mem[bus.paddr] <= bus.pwdata;
    end
  end

  // Reference model state
  logic [DW-1:0] m_mem [256];
  logic [DW-1:0] m_rdata;
  int            m_ptr;
  int            wait_cnt [N];
  op_t           ops [N][QD];
  int            q_head [N];
  int            q_cnt  [N];
  int            obs_log [256];
  int            n_log;

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic int pick(input logic [N-1:0] rv);
    for (int k = 0; k < N; k++) begin
      if (rv[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic int pending();
    int s;
    s = 0;
    for (int r = 0; r < N; r++) s += q_cnt[r];
    return s;
  endfunction

  function automatic int gnt_index(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr   = 0;
    m_rdata = '0;
    for (int i = 0; i < 256; i++) m_mem[i] = 8'(i) ^ 8'h5A;
    for (int r = 0; r < N; r++) begin
      q_head[r]   = 0;
      q_cnt[r]    = 0;
      wait_cnt[r] = 0;
    end
  endtask

  task automatic push(input int r, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    ops[r][(q_head[r] + q_cnt[r]) % QD] = '{wr: wr, addr: a, data: d};
    q_cnt[r]++;
  endtask

  // Each requester with queued work presents its oldest operation.
  task automatic present();
    op_t op;
    for (int r = 0; r < N; r++) begin
      if (q_cnt[r] > 0) begin
        op = ops[r][q_head[r]];
        bus.req[r]                   = 1'b1;
        bus.req_write[r]             = op.wr;
        bus.req_addr[r*AW +: AW]     = op.addr;
        bus.req_wdata[r*DW +: DW]    = op.data;
      end else begin
        bus.req[r] = 1'b0;
      end
    end
  endtask

  // Drain all queues, checking every phase of every transaction.
  task automatic run_queues(input string tag);
    int           guard;
    int           w;
    logic [N-1:0] rv;
    logic [N-1:0] oh;
    op_t          op;
    guard = 0;
    while (pending() > 0 && guard < 100) begin
      guard++;
      present();
      rv = bus.req;
      w  = pick(rv);
      if (w < 0) begin
        errors++;
        $display("FAIL %s no_winner req=%b", tag, rv);
        break;
      end
      op = ops[w][q_head[w]];
      oh = onehot(w);
      for (int i = 0; i < N; i++) begin
        if (i != w && rv[i]) begin
          wait_cnt[i]++;
          checks++;
          if (wait_cnt[i] > N - 1) begin
            errors++;
            $display("FAIL %s starvation req%0d waited %0d, limit %0d", tag, i, wait_cnt[i], N - 1);
          end
        end else begin
          wait_cnt[i] = 0;
        end
      end

      @(negedge clk);  // SETUP cycle
      checks++;
      if ({bus.gnt, bus.done, bus.psel, bus.penable, bus.busy} !== {oh, {N{1'b0}}, 3'b101}) begin
        errors++;
        $display("FAIL %s setup gnt=%b done=%b psel/pen/busy=%b%b%b exp gnt=%b done=0 101",
                 tag, bus.gnt, bus.done, bus.psel, bus.penable, bus.busy, oh);
      end
      checks++;
      if ({bus.pwrite, bus.paddr, bus.pwdata} !== {op.wr, op.addr, op.data}) begin
        errors++;
        $display("FAIL %s setup_fields got w=%b a=%h d=%h exp w=%b a=%h d=%h",
                 tag, bus.pwrite, bus.paddr, bus.pwdata, op.wr, op.addr, op.data);
      end
      if (n_log < 256) begin
        obs_log[n_log] = gnt_index(bus.gnt);
        n_log++;
      end
      q_head[w] = (q_head[w] + 1) % QD;
      q_cnt[w]--;
      wait_cnt[w] = 0;
      m_ptr = (w + 1) % N;
      present();

      @(negedge clk);  // ACCESS cycle
      checks++;
      if ({bus.gnt, bus.done, bus.psel, bus.penable, bus.busy, bus.paddr} !==
          {{N{1'b0}}, {N{1'b0}}, 3'b111, op.addr}) begin
        errors++;
        $display("FAIL %s access gnt=%b done=%b psel/pen/busy=%b%b%b paddr=%h exp 0 0 111 %h",
                 tag, bus.gnt, bus.done, bus.psel, bus.penable, bus.busy, bus.paddr, op.addr);
      end

      if (op.wr) begin
        m_mem[op.addr] = op.data;
      end else begin
        @(negedge clk);  // CAPTURE cycle
        checks++;
        if ({bus.gnt, bus.done, bus.psel, bus.penable, bus.busy} !== {{N{1'b0}}, {N{1'b0}}, 3'b001}) begin
          errors++;
          $display("FAIL %s capture gnt=%b done=%b psel/pen/busy=%b%b%b exp 0 0 001",
                   tag, bus.gnt, bus.done, bus.psel, bus.penable, bus.busy);
        end
        m_rdata = m_mem[op.addr];
      end

      @(negedge clk);  // done cycle (IDLE)
      checks++;
      if ({bus.gnt, bus.done, bus.psel, bus.penable, bus.busy, bus.rdata, bus.paddr} !==
          {{N{1'b0}}, oh, 3'b000, m_rdata, op.addr}) begin
        errors++;
        $display("FAIL %s done gnt=%b done=%b psel/pen/busy=%b%b%b rdata=%h paddr=%h exp 0 %b 000 %h %h",
                 tag, bus.gnt, bus.done, bus.psel, bus.penable, bus.busy, bus.rdata, bus.paddr,
                 oh, m_rdata, op.addr);
      end
    end
    if (guard >= 100) begin
      errors++;
      $display("FAIL %s guard transaction budget exhausted", tag);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.gnt, bus.done, bus.rdata, bus.busy, bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata} !== '0) begin
      errors++;
      $display("FAIL reset outputs gnt=%b done=%b rdata=%h busy=%b psel=%b pen=%b pw=%b pa=%h pd=%h exp all 0",
               bus.gnt, bus.done, bus.rdata, bus.busy, bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_single_write();
    push(0, 1'b1, 8'h10, 8'hA5);
    run_queues("single_write");
  endtask

  task automatic test_read_after_write();
    push(1, 1'b0, 8'h10, 8'($urandom));
    run_queues("read_after_write");
    checks++;
    if (bus.rdata !== 8'hA5) begin
      errors++;
      $display("FAIL raw_rdata got %h exp a5", bus.rdata);
    end
  endtask

  task automatic test_contention();
    n_log = 0;
    for (int k = 0; k < 4; k++) begin
      push(0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));
      push(1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));
    end
    run_queues("contention");
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (obs_log[k] !== k % 2) begin
        errors++;
        $display("FAIL contention_order grant %0d went to %0d exp %0d", k, obs_log[k], k % 2);
      end
    end
  endtask

  task automatic test_wrap();
    push(2, 1'b1, 8'h20, 8'h3C);
    run_queues("wrap_prep");
    n_log = 0;
    push(0, 1'b0, 8'h20, 8'h00);
    push(3, 1'b1, 8'h21, 8'hC3);
    run_queues("wrap");
    checks++;
    if (obs_log[0] !== 3 || obs_log[1] !== 0) begin
      errors++;
      $display("FAIL wrap_order got %0d,%0d exp 3,0", obs_log[0], obs_log[1]);
    end
  endtask

  task automatic test_idle();
    int ptr0;
    ptr0 = m_ptr;
    bus.req = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if ({bus.psel, bus.penable, bus.busy, bus.gnt, bus.done} !== '0) begin
        errors++;
        $display("FAIL idle cycle %0d psel=%b pen=%b busy=%b gnt=%b done=%b exp all 0",
                 c, bus.psel, bus.penable, bus.busy, bus.gnt, bus.done);
      end
    end
    n_log = 0;
    for (int r = 0; r < N; r++) push(r, 1'b1, 8'(8'h30 + r), 8'($urandom));
    run_queues("idle_resume");
    checks++;
    if (obs_log[0] !== ptr0) begin
      errors++;
      $display("FAIL idle_pointer first grant %0d exp %0d", obs_log[0], ptr0);
    end
  endtask

  task automatic test_reset_mid();
    bus.req                  = onehot(2);
    bus.req_write[2]         = 1'b0;
    bus.req_addr[2*AW +: AW] = 8'h30;
    @(negedge clk);
    checks++;
    if (bus.gnt !== onehot(2)) begin
      errors++;
      $display("FAIL rst_mid gnt got %b exp %b", bus.gnt, onehot(2));
    end
    bus.req = '0;
    @(negedge clk);
    checks++;
    if ({bus.psel, bus.penable} !== 2'b11) begin
      errors++;
      $display("FAIL rst_mid access psel/pen got %b%b exp 11", bus.psel, bus.penable);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    checks++;
    if ({bus.gnt, bus.done, bus.rdata, bus.busy, bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata} !== '0) begin
      errors++;
      $display("FAIL rst_mid outputs gnt=%b done=%b rdata=%h busy=%b psel=%b pen=%b pw=%b pa=%h pd=%h exp all 0",
               bus.gnt, bus.done, bus.rdata, bus.busy, bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if ({bus.done, bus.busy} !== '0) begin
        errors++;
        $display("FAIL rst_mid quiet cycle %0d done=%b busy=%b exp 0", c, bus.done, bus.busy);
      end
    end
    n_log = 0;
    push(0, 1'b0, 8'h30, 8'h00);
    push(3, 1'b1, 8'h31, 8'h77);
    run_queues("after_reset");
    checks++;
    if (obs_log[0] !== 0) begin
      errors++;
      $display("FAIL rst_mid pointer first grant %0d exp 0", obs_log[0]);
    end
  endtask

  task automatic test_random();
    for (int round = 0; round < 3; round++) begin
      for (int r = 0; r < N; r++) begin
        int cnt;
        cnt = int'($urandom_range(0, 4));
        for (int k = 0; k < cnt; k++) begin
          push(r, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));
        end
      end
      run_queues("random");
    end
  endtask

  initial begin
    bus.req       = '0;
    bus.req_write = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    n_log         = 0;
    model_reset();

    test_reset();
    test_single_write();
    test_read_after_write();
    test_contention();
    test_wrap();
    test_idle();
    test_reset_mid();
    test_random();

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
